// File: rtl/tcam_pkg.sv
// Shared types and default sizing for the TCAM column write controller.
package tcam_pkg;

  localparam int TCAM_SEGS       = 4;
  localparam int TCAM_SEG_BITS   = 7;
  localparam int TCAM_ADDR_WIDTH = 8;
  localparam int TCAM_DATA_WIDTH = 32;
  localparam int TCAM_NUM_WMASKS = 4;
  localparam int ENTRY_W         = 5;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_INVAL = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tcam_seg_match.sv
// One segment of the sweep: decides whether this SRAM row matches the
// entry's ternary key segment and rewrites the entry's bit in the read word.
module tcam_seg_match
  import tcam_pkg::*;
#(
  parameter int SEG_BITS   = TCAM_SEG_BITS,
  parameter int DATA_WIDTH = TCAM_DATA_WIDTH
) (
  input  logic [SEG_BITS-1:0]   row,
  input  logic [SEG_BITS-1:0]   key_s,
  input  logic [SEG_BITS-1:0]   care_s,
  input  logic [DATA_WIDTH-1:0] dout_s,
  input  logic [ENTRY_W-1:0]    entry,
  input  logic                  op,
  output logic [DATA_WIDTH-1:0] new_s
);

  logic hit;

  // Don't-care bits are masked out before comparing the row to the key.
  assign hit = (((row ^ key_s) & care_s) == '0);

  // Every other bit of the word is written back as read.
  always_comb begin
    new_s        = dout_s;
    new_s[entry] = (op == OP_WRITE) ? hit : 1'b0;
  end

endmodule

// File: rtl/tcam_write_ctrl.sv
// TCAM column update engine: clears the column after reset, then turns each
// entry write/invalidate into a read-modify-write sweep over all SRAM rows.
// Bus outputs are registered; each state's combinational outputs describe
// what the bus carries in the following cycle.
module tcam_write_ctrl
  import tcam_pkg::*;
#(
  parameter int SEGS       = TCAM_SEGS,
  parameter int SEG_BITS   = TCAM_SEG_BITS,
  parameter int ADDR_WIDTH = TCAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = TCAM_DATA_WIDTH,
  parameter int NUM_WMASKS = TCAM_NUM_WMASKS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_op,
  input  logic [ENTRY_W-1:0]         req_entry,
  input  logic [SEGS*SEG_BITS-1:0]   req_key,
  input  logic [SEGS*SEG_BITS-1:0]   req_care,
  output logic                       done,
  output logic                       busy,
  output logic                       sram_csb0,
  output logic                       sram_web0,
  output logic [NUM_WMASKS-1:0]      sram_wmask0,
  output logic [ADDR_WIDTH-1:0]      sram_addr0,
  output logic [SEGS*DATA_WIDTH-1:0] sram_din0,
  input  logic [SEGS*DATA_WIDTH-1:0] sram_dout0
);

  localparam logic [SEG_BITS-1:0] LAST_ROW = '1;

  state_t                     state, state_nxt;
  logic [SEG_BITS-1:0]        row, row_inc;
  logic                       accept, last_row;

  logic                       op_q;
  logic [ENTRY_W-1:0]         entry_q;
  logic [SEGS*SEG_BITS-1:0]   key_q, care_q;
  logic [SEGS*DATA_WIDTH-1:0] new_word;

  logic                       csb_d, web_d, ready_d, busy_d, done_d;
  logic [NUM_WMASKS-1:0]      wmask_d;
  logic [ADDR_WIDTH-1:0]      addr_d;
  logic [SEGS*DATA_WIDTH-1:0] din_d;

  function automatic logic [NUM_WMASKS-1:0] lane_onehot(input logic [1:0] lane);
    lane_onehot       = '0;
    lane_onehot[lane] = 1'b1;
  endfunction

  assign accept   = (state == ST_IDLE) && req_valid && req_ready;
  assign last_row = (row == LAST_ROW);
  assign row_inc  = row + SEG_BITS'(1);

  for (genvar s = 0; s < SEGS; s++) begin : g_seg
    tcam_seg_match #(
      .SEG_BITS  (SEG_BITS),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_match (
      .row   (row),
      .key_s (key_q[s*SEG_BITS +: SEG_BITS]),
      .care_s(care_q[s*SEG_BITS +: SEG_BITS]),
      .dout_s(sram_dout0[s*DATA_WIDTH +: DATA_WIDTH]),
      .entry (entry_q),
      .op    (op_q),
      .new_s (new_word[s*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // State and row counter; the counter walks rows in INIT and advances after each WR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      row   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT || state == ST_WR) row <= row_inc;
      else if (accept)                        row <= '0;
    end
  end

  // Request fields are held for the whole sweep; they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= req_op;
      entry_q <= req_entry;
      key_q   <= req_key;
      care_q  <= req_care;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: state_nxt = last_row ? ST_IDLE : ST_INIT;
      ST_IDLE: state_nxt = accept ? ST_RD : ST_IDLE;
      ST_RD:   state_nxt = ST_CAP;
      ST_CAP:  state_nxt = ST_WR;
      ST_WR:   state_nxt = last_row ? ST_DONE : ST_RD;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Output logic: the bus command and handshake seen in the next cycle.
  always_comb begin
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = '0;
    addr_d  = sram_addr0;
    din_d   = sram_din0;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    case (state)
      ST_INIT: begin
        csb_d   = 1'b0;
        web_d   = 1'b0;
        wmask_d = '1;
        addr_d  = ADDR_WIDTH'(row);
        din_d   = '0;
      end
      ST_IDLE: begin
        if (accept) begin
          csb_d  = 1'b0;
          addr_d = '0;
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      // Read data for this row is on sram_dout0 during CAP.
      ST_CAP: begin
        csb_d   = 1'b0;
        web_d   = 1'b0;
        wmask_d = lane_onehot(entry_q[4:3]);
        addr_d  = ADDR_WIDTH'(row);
        din_d   = new_word;
      end
      ST_WR: begin
        if (!last_row) begin
          csb_d  = 1'b0;
          addr_d = ADDR_WIDTH'(row_inc);
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      req_ready   <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
    end else begin
      sram_csb0   <= csb_d;
      sram_web0   <= web_d;
      sram_wmask0 <= wmask_d;
      sram_addr0  <= addr_d;
      sram_din0   <= din_d;
      req_ready   <= ready_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_tcam_write_ctrl.sv
// Directed bench for tcam_write_ctrl with a behavioural SRAM bank and a
// queue of expected port-0 writes built from an independent table model.
module tb_tcam_write_ctrl;
  import tcam_pkg::*;

  localparam int SEGS       = 4;
  localparam int SEG_BITS   = 7;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WMASKS = 4;
  localparam int ROWS       = 1 << SEG_BITS;
  localparam int KW         = SEGS * SEG_BITS;
  localparam int BW         = SEGS * DATA_WIDTH;
  localparam int LAT        = 3 * ROWS + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_valid = 1'b0;
  logic                  req_op = 1'b0;
  logic [4:0]            req_entry = '0;
  logic [KW-1:0]         req_key = '0;
  logic [KW-1:0]         req_care = '0;
  logic                  req_ready, done, busy, sram_csb0, sram_web0;
  logic [NUM_WMASKS-1:0] sram_wmask0;
  logic [ADDR_WIDTH-1:0] sram_addr0;
  logic [BW-1:0]         sram_din0;
  logic [BW-1:0]         sram_dout0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [NUM_WMASKS-1:0] wmask;
    logic [BW-1:0]         din;
  } wr_t;

  wr_t             exp_q[$];
  logic [DATA_WIDTH-1:0] mem     [SEGS][256];
  logic [DATA_WIDTH-1:0] ref_tab [SEGS][ROWS];
  bit              filled = 1'b0;
  int              n_cmp  = 0;
  int              n_fail = 0;

  tcam_write_ctrl #(
    .SEGS(SEGS), .SEG_BITS(SEG_BITS), .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .NUM_WMASKS(NUM_WMASKS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_entry(req_entry), .req_key(req_key), .req_care(req_care),
    .done(done), .busy(busy),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SRAM bank: inputs sampled at the rising edge, read data valid the next cycle.
  always @(posedge clk) begin
    if (!filled) begin
      for (int s = 0; s < SEGS; s++)
        for (int r = 0; r < 256; r++) mem[s][r] <= $urandom();
      filled <= 1'b1;
    end else if (sram_csb0 === 1'b0) begin
      for (int s = 0; s < SEGS; s++) begin
        if (sram_web0 === 1'b0) begin
          for (int b = 0; b < NUM_WMASKS; b++)
            if (sram_wmask0[b])
              mem[s][sram_addr0][b*8 +: 8] <= sram_din0[s*DATA_WIDTH + b*8 +: 8];
        end else begin
          sram_dout0[s*DATA_WIDTH +: DATA_WIDTH] <= mem[s][sram_addr0];
        end
      end
    end
  end

  // Every port-0 write is matched against the next expected write.
  always @(negedge clk) begin : wr_mon
    wr_t e;
    if (rst === 1'b0 && sram_csb0 === 1'b0 && sram_web0 === 1'b0) begin
      check("wr_pending", BW'(exp_q.size() != 0), BW'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("wr_addr_%0d", e.addr), BW'(sram_addr0), BW'(e.addr));
        check($sformatf("wr_mask_%0d", e.addr), BW'(sram_wmask0), BW'(e.wmask));
        check($sformatf("wr_din_%0d", e.addr), sram_din0, e.din);
      end
    end
  end

  task automatic do_reset_init();
    wr_t e;
    int  k;
    rst = 1'b1;
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      e.addr  = ADDR_WIDTH'(r);
      e.wmask = 4'hF;
      e.din   = '0;
      exp_q.push_back(e);
      for (int s = 0; s < SEGS; s++) ref_tab[s][r] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_csb",   BW'(sram_csb0),   BW'(1));
    check("rst_web",   BW'(sram_web0),   BW'(1));
    check("rst_wmask", BW'(sram_wmask0), BW'(0));
    check("rst_addr",  BW'(sram_addr0),  BW'(0));
    check("rst_din",   sram_din0,        BW'(0));
    check("rst_ready", BW'(req_ready),   BW'(0));
    check("rst_done",  BW'(done),        BW'(0));
    check("rst_busy",  BW'(busy),        BW'(1));
    rst = 1'b0;
    k = 0;
    while (req_ready !== 1'b1 && k < 400) begin
      @(posedge clk); #1; k++;
    end
    req_valid = 1'b0;
    check("init_cycles", BW'(k), BW'(ROWS + 1));
    check("init_busy", BW'(busy), BW'(0));
    check("init_writes_left", BW'(exp_q.size()), BW'(0));
  endtask

  task automatic readback(input string tag);
    for (int s = 0; s < SEGS; s++)
      for (int r = 0; r < ROWS; r++)
        check($sformatf("%s_s%0d_r%0d", tag, s, r), BW'(mem[s][r]), BW'(ref_tab[s][r]));
  endtask

  // Queues the expected sweep, issues the request and (unless aborting)
  // waits for done; abort_row >= 0 returns while that row is being read.
  task automatic do_update(input string tag, input logic op, input logic [4:0] entry,
                           input logic [KW-1:0] key, input logic [KW-1:0] care,
                           input int abort_row);
    wr_t                   e;
    logic [SEG_BITS-1:0]   ks, cs, rr;
    logic [DATA_WIDTH-1:0] v;
    logic                  m;
    int                    k;
    for (int r = 0; r < ROWS; r++) begin
      rr      = SEG_BITS'(r);
      e.addr  = ADDR_WIDTH'(r);
      e.wmask = 4'b0001 << (entry / 8);
      for (int s = 0; s < SEGS; s++) begin
        ks = key[s*SEG_BITS +: SEG_BITS];
        cs = care[s*SEG_BITS +: SEG_BITS];
        m  = 1'b1;
        for (int b = 0; b < SEG_BITS; b++)
          if (cs[b] && (rr[b] != ks[b])) m = 1'b0;
        v = ref_tab[s][r];
        v[entry] = op ? 1'b0 : m;
        ref_tab[s][r] = v;
        e.din[s*DATA_WIDTH +: DATA_WIDTH] = v;
      end
      exp_q.push_back(e);
    end
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check({tag, "_ready"}, BW'(req_ready), BW'(1));
    req_valid = 1'b1; req_op = op; req_entry = entry; req_key = key; req_care = care;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_busy_after_accept"}, BW'(busy), BW'(1));
    check({tag, "_ready_after_accept"}, BW'(req_ready), BW'(0));
    k = 0;
    if (abort_row >= 0) begin
      while (k < 3 * abort_row) begin
        @(posedge clk); #1; k++;
      end
      check({tag, "_abort_csb"},  BW'(sram_csb0),  BW'(0));
      check({tag, "_abort_addr"}, BW'(sram_addr0), BW'(abort_row));
      return;
    end
    while (done !== 1'b1 && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    check({tag, "_latency"}, BW'(k), BW'(LAT));
    check({tag, "_done_ready"}, BW'(req_ready), BW'(1));
    check({tag, "_done_busy"}, BW'(busy), BW'(0));
    check({tag, "_writes_left"}, BW'(exp_q.size()), BW'(0));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, BW'(done), BW'(0));
    check({tag, "_idle_csb"}, BW'(sram_csb0), BW'(1));
  endtask

  initial begin
    do_reset_init();
    readback("init");

    do_update("wr5", 1'b0, 5'd5, 28'h0000000, 28'hFFFFFFF, -1);
    readback("wr5");

    do_update("wr8", 1'b0, 5'd8, 28'h0000000, 28'h0000000, -1);
    do_update("wr9", 1'b0, 5'd9, 28'h0000030, 28'h0000070, -1);
    readback("wr9");

    do_update("inv5", 1'b1, 5'd5, 28'h0000000, 28'h0000000, -1);
    readback("inv5");

    repeat (3) begin
      @(posedge clk); #1;
      check("idle_quiet", BW'(sram_csb0), BW'(1));
    end

    do_update("abort", 1'b0, 5'd3, 28'h5A5A5A5, 28'h0F0F0F0, 40);
    rst = 1'b1;
    #1;
    check("midrst_csb",   BW'(sram_csb0), BW'(1));
    check("midrst_web",   BW'(sram_web0), BW'(1));
    check("midrst_din",   sram_din0,      BW'(0));
    check("midrst_ready", BW'(req_ready), BW'(0));
    check("midrst_busy",  BW'(busy),      BW'(1));
    req_valid = 1'b1; req_op = 1'b0; req_entry = 5'd17;
    req_key = 28'h0; req_care = 28'h0;
    do_reset_init();
    repeat (3) begin
      @(posedge clk); #1;
      check("post_init_quiet", BW'(sram_csb0), BW'(1));
    end
    readback("reinit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
